// File: rtl/spi_arb_pkg.sv
// rtl/spi_arb_pkg.sv - shared types and sizes for the two-master SPI flash arbiter
package spi_arb_pkg;

  localparam int NUM_MASTERS = 2;
  localparam int SD_W        = 4;
  localparam int OWNER_W     = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_GUARD = 2'd2
  } arb_state_e;

  function automatic logic [NUM_MASTERS-1:0] owner_onehot(input logic [OWNER_W-1:0] owner);
    logic [NUM_MASTERS-1:0] oh;
    oh = '0;
    oh[owner] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/spi_arb_rr.sv
// rtl/spi_arb_rr.sv - two-way round-robin pick; on a tie the master that did not own last wins
module spi_arb_rr
  import spi_arb_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [OWNER_W-1:0]     last_owner,
  output logic                   valid,
  output logic [OWNER_W-1:0]     owner
);

  always_comb begin
    valid = |req;
    owner = last_owner;
    if (req[0] && req[1]) begin
      owner = ~last_owner;
    end else if (req[1]) begin
      owner = 1'b1;
    end else if (req[0]) begin
      owner = 1'b0;
    end
  end

endmodule

// File: rtl/spi_flash_arbiter.sv
// rtl/spi_flash_arbiter.sv - shares one SPI flash between two masters with guard gap
// Define SPI_ARB_TIMEOUT_EN to add a forced release after TIMEOUT_CYCLES of ownership.
module spi_flash_arbiter
  import spi_arb_pkg::*;
#(
  parameter int GUARD_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_MASTERS-1:0]       req_i,
  output logic [NUM_MASTERS-1:0]       gnt_o,
  input  logic [NUM_MASTERS-1:0]       m_csb_i,
  input  logic [NUM_MASTERS-1:0]       m_sck_i,
  input  logic [NUM_MASTERS*SD_W-1:0]  m_sd_i,
  input  logic [NUM_MASTERS*SD_W-1:0]  m_sd_oe_i,
  output logic [NUM_MASTERS*SD_W-1:0]  m_sd_o,
  output logic                         flash_csb_o,
  output logic                         flash_sck_o,
  output logic [SD_W-1:0]              flash_sd_o,
  output logic [SD_W-1:0]              flash_sd_oe_o,
  input  logic [SD_W-1:0]              flash_sd_i,
  output logic                         violation_o,
  output logic                         timeout_o
);

  localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYCLES - 1);

  arb_state_e             state;
  logic [OWNER_W-1:0]     owner;
  logic [OWNER_W-1:0]     last_owner;
  logic [NUM_MASTERS-1:0] gnt;
  logic [GW-1:0]          guard_cnt;
  logic                   violation;

  logic [NUM_MASTERS-1:0] arb_req;
  logic                   rr_valid;
  logic [OWNER_W-1:0]     rr_owner;
  logic                   release_ok;
  logic                   force_release;
  logic                   own_end;

  // Release needs both: owner no longer asking and its transfer has ended.
  assign release_ok = (state == ST_OWN) && !req_i[owner] && m_csb_i[owner];
  assign own_end    = release_ok || force_release;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0]          to_cnt;
  logic [NUM_MASTERS-1:0] mask;
  logic                   timeout_q;
  logic                   to_hit;

  assign to_hit        = (state == ST_OWN) && (to_cnt == TIMEOUT_LAST);
  assign force_release = to_hit && !release_ok;
  assign arb_req       = req_i & ~mask;
  assign timeout_o     = timeout_q;

  // A timed-out master stays masked until it lets go of its request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      to_cnt    <= '0;
      mask      <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= force_release;
      mask      <= (mask & req_i) | (force_release ? owner_onehot(owner) : '0);
      if (state == ST_OWN && !own_end) begin
        to_cnt <= to_cnt + 1'b1;
      end else begin
        to_cnt <= '0;
      end
    end
  end
`else
  assign force_release = 1'b0;
  assign arb_req       = req_i;
  assign timeout_o     = 1'b0;
`endif

  spi_arb_rr u_rr (
    .req        (arb_req),
    .last_owner (last_owner),
    .valid      (rr_valid),
    .owner      (rr_owner)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      owner      <= '0;
      last_owner <= 1'b1;
      gnt        <= '0;
      guard_cnt  <= '0;
      violation  <= 1'b0;
    end else begin
      violation <= violation | (|(~m_csb_i & ~gnt));
      case (state)
        ST_IDLE: begin
          if (rr_valid) begin
            state      <= ST_OWN;
            owner      <= rr_owner;
            last_owner <= rr_owner;
            gnt        <= owner_onehot(rr_owner);
          end
        end
        ST_OWN: begin
          if (own_end) begin
            gnt <= '0;
            if (GUARD_CYCLES == 0) begin
              state <= ST_IDLE;
            end else begin
              state     <= ST_GUARD;
              guard_cnt <= GUARD_LOAD;
            end
          end
        end
        ST_GUARD: begin
          if (guard_cnt == '0) begin
            state <= ST_IDLE;
          end else begin
            guard_cnt <= guard_cnt - 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          gnt   <= '0;
        end
      endcase
    end
  end

  // Pin mux is combinational so the owner sees no extra latency to the flash.
  always_comb begin
    flash_csb_o   = 1'b1;
    flash_sck_o   = 1'b0;
    flash_sd_o    = '0;
    flash_sd_oe_o = '0;
    m_sd_o        = '0;
    if (state == ST_OWN) begin
      for (int k = 0; k < NUM_MASTERS; k++) begin
        if (OWNER_W'(k) == owner) begin
          flash_csb_o                = m_csb_i[k];
          flash_sck_o                = m_sck_i[k];
          flash_sd_o                 = m_sd_i[k*SD_W +: SD_W];
          flash_sd_oe_o              = m_sd_oe_i[k*SD_W +: SD_W];
          m_sd_o[k*SD_W +: SD_W]     = flash_sd_i;
        end
      end
    end
  end

  assign gnt_o       = gnt;
  assign violation_o = violation;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// tb/tb_spi_flash_arbiter.sv - directed vector table plus corner sequences for spi_flash_arbiter
module tb_spi_flash_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req, gnt, csb, sck;
  logic [7:0] m_sd, m_oe, m_sd_o;
  logic       fcsb, fsck;
  logic [3:0] fsd, foe, fsd_in;
  logic       viol, tmo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_flash_arbiter #(.GUARD_CYCLES(2), .TIMEOUT_CYCLES(16)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_i         (req),
    .gnt_o         (gnt),
    .m_csb_i       (csb),
    .m_sck_i       (sck),
    .m_sd_i        (m_sd),
    .m_sd_oe_i     (m_oe),
    .m_sd_o        (m_sd_o),
    .flash_csb_o   (fcsb),
    .flash_sck_o   (fsck),
    .flash_sd_o    (fsd),
    .flash_sd_oe_o (foe),
    .flash_sd_i    (fsd_in),
    .violation_o   (viol),
    .timeout_o     (tmo)
  );

  typedef struct {
    logic       rst;
    logic [1:0] req, csb, sck;
    logic [7:0] sd, oe;
    logic [3:0] fin;
    logic [1:0] e_gnt;
    logic       e_csb, e_sck;
    logic [3:0] e_sd, e_oe;
    logic [7:0] e_msdo;
    logic       e_viol;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic [1:0] rq, input logic [1:0] cs,
                              input logic [1:0] sk, input logic [7:0] sd, input logic [7:0] oe,
                              input logic [3:0] fin, input logic [1:0] eg, input logic ec,
                              input logic es, input logic [3:0] ed, input logic [3:0] eo,
                              input logic [7:0] em, input logic ev);
    vec_t v;
    v.rst = r; v.req = rq; v.csb = cs; v.sck = sk; v.sd = sd; v.oe = oe; v.fin = fin;
    v.e_gnt = eg; v.e_csb = ec; v.e_sck = es; v.e_sd = ed; v.e_oe = eo;
    v.e_msdo = em; v.e_viol = ev;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_gnt(input logic [1:0] want, input string nm);
    int n;
    n = 0;
    while (gnt !== want && n < 10) begin
      tick();
      n++;
    end
    chk(nm, 32'(gnt), 32'(want));
  endtask

  task automatic drive(input logic [1:0] rq, input logic [1:0] cs);
    req = rq;
    csb = cs;
  endtask

  initial begin
    rst = 1'b1; req = '0; csb = 2'b11; sck = '0; m_sd = '0; m_oe = '0; fsd_in = '0;
    tick();
    tick();

    // rst req csb sck sd oe fin | gnt csb sck sd oe m_sd_o viol
    tbl.push_back(mk(1, 2'b00, 2'b11, 2'b00, 8'h00, 8'h00, 4'h0, 2'b00, 1, 0, 4'h0, 4'h0, 8'h00, 0));
    tbl.push_back(mk(0, 2'b11, 2'b11, 2'b00, 8'h00, 8'h00, 4'h0, 2'b00, 1, 0, 4'h0, 4'h0, 8'h00, 0));
    tbl.push_back(mk(0, 2'b11, 2'b10, 2'b01, 8'hBA, 8'hFF, 4'h3, 2'b01, 0, 1, 4'hA, 4'hF, 8'h03, 0));
    tbl.push_back(mk(0, 2'b11, 2'b10, 2'b00, 8'hB5, 8'hFF, 4'hC, 2'b01, 0, 0, 4'h5, 4'hF, 8'h0C, 0));
    tbl.push_back(mk(0, 2'b10, 2'b11, 2'b00, 8'h00, 8'h00, 4'h7, 2'b01, 1, 0, 4'h0, 4'h0, 8'h07, 0));
    tbl.push_back(mk(0, 2'b10, 2'b11, 2'b00, 8'h00, 8'h00, 4'h7, 2'b00, 1, 0, 4'h0, 4'h0, 8'h00, 0));
    tbl.push_back(mk(0, 2'b10, 2'b11, 2'b00, 8'h00, 8'h00, 4'h7, 2'b00, 1, 0, 4'h0, 4'h0, 8'h00, 0));
    tbl.push_back(mk(0, 2'b10, 2'b11, 2'b00, 8'h00, 8'h00, 4'h7, 2'b00, 1, 0, 4'h0, 4'h0, 8'h00, 0));
    tbl.push_back(mk(0, 2'b10, 2'b01, 2'b10, 8'h62, 8'hF0, 4'h9, 2'b10, 0, 1, 4'h6, 4'hF, 8'h90, 0));
    tbl.push_back(mk(0, 2'b00, 2'b11, 2'b00, 8'h00, 8'h00, 4'h9, 2'b10, 1, 0, 4'h0, 4'h0, 8'h90, 0));
    tbl.push_back(mk(0, 2'b00, 2'b11, 2'b00, 8'h00, 8'h00, 4'h9, 2'b00, 1, 0, 4'h0, 4'h0, 8'h00, 0));
    tbl.push_back(mk(0, 2'b00, 2'b11, 2'b00, 8'h00, 8'h00, 4'h9, 2'b00, 1, 0, 4'h0, 4'h0, 8'h00, 0));
    tbl.push_back(mk(0, 2'b00, 2'b11, 2'b00, 8'h00, 8'h00, 4'h9, 2'b00, 1, 0, 4'h0, 4'h0, 8'h00, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; req = tbl[i].req; csb = tbl[i].csb; sck = tbl[i].sck;
      m_sd = tbl[i].sd; m_oe = tbl[i].oe; fsd_in = tbl[i].fin;
      #1;
      chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(tbl[i].e_gnt));
      chk($sformatf("v%0d_fcsb", i), 32'(fcsb), 32'(tbl[i].e_csb));
      chk($sformatf("v%0d_fsck", i), 32'(fsck), 32'(tbl[i].e_sck));
      chk($sformatf("v%0d_fsd", i), 32'(fsd), 32'(tbl[i].e_sd));
      chk($sformatf("v%0d_foe", i), 32'(foe), 32'(tbl[i].e_oe));
      chk($sformatf("v%0d_msdo", i), 32'(m_sd_o), 32'(tbl[i].e_msdo));
      chk($sformatf("v%0d_viol", i), 32'(viol), 32'(tbl[i].e_viol));
      chk($sformatf("v%0d_tmo", i), 32'(tmo), 32'd0);
      tick();
    end
    sck = '0; m_sd = '0; m_oe = '0; fsd_in = '0;

    // Master 0 drops req mid-transfer; grant held until csb rises, then 2 guard cycles.
    drive(2'b01, 2'b11);
    tick();
    chk("t2_grant", 32'(gnt), 32'(2'b01));
    drive(2'b01, 2'b10);
    tick();
    drive(2'b00, 2'b10);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("t2_hold%0d_gnt", i), 32'(gnt), 32'(2'b01));
      chk($sformatf("t2_hold%0d_fcsb", i), 32'(fcsb), 32'd0);
      tick();
    end
    drive(2'b10, 2'b11);
    #1;
    chk("t2_rel_gnt", 32'(gnt), 32'(2'b01));
    tick();
    drive(2'b11, 2'b11);
    #1;
    chk("t2_g1_gnt", 32'(gnt), 32'(2'b00));
    chk("t2_g1_fcsb", 32'(fcsb), 32'd1);
    tick();
    chk("t2_g2_gnt", 32'(gnt), 32'(2'b00));
    chk("t2_g2_fcsb", 32'(fcsb), 32'd1);
    tick();
    chk("t2_idle_gnt", 32'(gnt), 32'(2'b00));
    tick();
    chk("t2_rr_gnt", 32'(gnt), 32'(2'b10));

    // Master 1 pulls csb low while master 0 owns.
    drive(2'b00, 2'b11);
    tick(); tick(); tick();
    drive(2'b01, 2'b11);
    tick();
    chk("t3_grant", 32'(gnt), 32'(2'b01));
    chk("t3_viol_pre", 32'(viol), 32'd0);
    drive(2'b01, 2'b00);
    m_sd = 8'hC3; m_oe = 8'hFF; sck = 2'b10;
    #1;
    chk("t3_fsd", 32'(fsd), 32'h3);
    chk("t3_fsck", 32'(fsck), 32'd0);
    chk("t3_fcsb", 32'(fcsb), 32'd0);
    tick();
    chk("t3_viol_set", 32'(viol), 32'd1);
    csb = 2'b10;
    tick();
    chk("t3_viol_hold", 32'(viol), 32'd1);
    chk("t3_fsd2", 32'(fsd), 32'h3);
    drive(2'b00, 2'b11);
    m_sd = '0; m_oe = '0; sck = '0;
    for (int i = 0; i < 4; i++) tick();
    chk("t3_viol_sticky", 32'(viol), 32'd1);

    // Reset in the middle of an ownership.
    drive(2'b01, 2'b11);
    wait_gnt(2'b01, "t5_grant");
    csb = 2'b10;
    #1;
    chk("t5_fcsb_low", 32'(fcsb), 32'd0);
    rst = 1'b1;
    tick();
    chk("t5_fcsb_rst", 32'(fcsb), 32'd1);
    chk("t5_gnt_rst", 32'(gnt), 32'(2'b00));
    chk("t5_viol_rst", 32'(viol), 32'd0);
    rst = 1'b0;
    drive(2'b11, 2'b11);
    tick();
    chk("t5_tie_gnt", 32'(gnt), 32'(2'b01));
    drive(2'b00, 2'b11);
    for (int i = 0; i < 4; i++) tick();
    chk("t5_idle_gnt", 32'(gnt), 32'(2'b00));

`ifdef SPI_ARB_TIMEOUT_EN
    begin
      int n;
      int regrant;
      drive(2'b01, 2'b11);
      tick();
      n = 0;
      while (gnt == 2'b01 && n < 50) begin
        n++;
        tick();
      end
      chk("t4_own_len", 32'(n), 32'd16);
      chk("t4_tmo_pulse", 32'(tmo), 32'd1);
      tick();
      chk("t4_tmo_end", 32'(tmo), 32'd0);
      regrant = 0;
      for (int i = 0; i < 22; i++) begin
        if (gnt != 2'b00) regrant++;
        tick();
      end
      chk("t4_masked", 32'(regrant), 32'd0);
      drive(2'b00, 2'b11);
      tick();
      drive(2'b01, 2'b11);
      wait_gnt(2'b01, "t4_regrant");
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_flash_arbiter.md
SPI_FLASH_ARBITER -- requirements
Module: spi_flash_arbiter

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter GUARD_CYCLES, default 2: idle cycles with flash deselected between two ownerships.
REQ-003 Parameter TIMEOUT_CYCLES, default 65535: maximum ownership length in cycles; used only when SPI_ARB_TIMEOUT_EN is defined.
REQ-004 Port clk_i  in  1  system clock.
REQ-005 Port rst_i  in  1  synchronous active-high reset.
REQ-006 Port req_i  in  2  per-master ownership request.
REQ-007 Port gnt_o  out  2  per-master grant, one-hot or zero.
REQ-008 Port m_csb_i  in  2  per-master chip select, active low.
REQ-009 Port m_sck_i  in  2  per-master serial clock.
REQ-010 Port m_sd_i  in  2x4  per-master data out.
REQ-011 Port m_sd_oe_i  in  2x4  per-master output enables.
REQ-012 Port m_sd_o  out  2x4  flash read data returned to each master.
REQ-013 Port flash_csb_o  out  1  shared flash chip select.
REQ-014 Port flash_sck_o  out  1  shared flash clock.
REQ-015 Port flash_sd_o  out  4  shared flash data out.
REQ-016 Port flash_sd_oe_o  out  4  shared flash output enables.
REQ-017 Port flash_sd_i  in  4  shared flash data in.
REQ-018 Port violation_o  out  1  sticky flag: a master drove its csb low without a grant.
REQ-019 Port timeout_o  out  1  one-cycle pulse on forced release.

Function
REQ-020 The FSM SHALL have three states: IDLE, OWN and GUARD; an owner register SHALL select the active master.
REQ-021 IDLE: if any req_i bit is set, the arbiter SHALL pick an owner, enter OWN next cycle and assert gnt_o[owner] from that cycle on.
REQ-022 Simultaneous requests SHALL be resolved round-robin: the master that was not the last owner wins.
REQ-023 OWN SHALL persist until req_i[owner]=0 and m_csb_i[owner]=1 in the same cycle; the FSM SHALL then enter GUARD and gnt_o SHALL become 0 in that same transition cycle.
REQ-024 If req_i[owner] drops while m_csb_i[owner]=0, the grant SHALL be held until csb returns high.
REQ-025 GUARD SHALL last exactly GUARD_CYCLES cycles, then go to IDLE; with GUARD_CYCLES=0, OWN SHALL go directly to IDLE.
REQ-026 In OWN, flash_* outputs SHALL combinationally follow the owner's m_* inputs (zero added latency).
REQ-027 Outside OWN: flash_csb_o=1, flash_sck_o=0, flash_sd_o=0 and flash_sd_oe_o=0.
REQ-028 m_sd_o[owner] SHALL equal flash_sd_i in OWN; every non-owner m_sd_o SHALL be 0.
REQ-029 violation_o SHALL set on any cycle where m_csb_i[k]=0 and gnt_o[k]=0, and SHALL be cleared only by reset; that master's signals SHALL never reach the flash.
REQ-030 An owner's requests SHALL not be re-arbitrated until the FSM returns to IDLE.

Reset
REQ-031 On rst_i the block SHALL enter IDLE with gnt_o=0, flash_csb_o=1, flash_sck_o=0, flash_sd_o=0, flash_sd_oe_o=0, violation_o=0, timeout_o=0 and the timeout counter at 0.
REQ-032 Reset SHALL set last-owner to master 1, so master 0 wins the first tie.
REQ-033 Reset asserted mid-ownership SHALL force flash_csb_o high in the cycle after the reset edge, abandoning the transfer.

Configuration
REQ-034 With SPI_ARB_TIMEOUT_EN defined, a counter SHALL count cycles in OWN.
REQ-035 When that counter reaches TIMEOUT_CYCLES, the block SHALL force GUARD, pulse timeout_o for one cycle and mask that master until its req_i deasserts.
REQ-036 Without SPI_ARB_TIMEOUT_EN, no counter logic SHALL exist and timeout_o SHALL be tied to 0.

Structure
REQ-037 A shared package spi_arb_pkg SHALL hold the FSM state enum, NUM_MASTERS=2 and SD_W=4.
REQ-038 Round-robin selection SHALL live in sub-module spi_arb_rr (inputs: req, last owner; outputs: valid, owner).

Verification
REQ-039 Test 1: req_i=2'b11 at the first cycle after reset -> gnt_o=2'b01 next cycle; after master 0 releases and 2 guard cycles, gnt_o=2'b10.
REQ-040 Test 2: master 0 owns, drops req_i while csb is low for 5 more cycles -> gnt_o[0] held for those 5 cycles, then 2 cycles with flash_csb_o=1, then IDLE.
REQ-041 Test 3: master 1 drives csb low without a grant while master 0 owns -> violation_o=1 stays set; flash pins track master 0 only.
REQ-042 Test 4: with SPI_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, master 0 holds req for 40 cycles -> timeout_o pulses at cycle 16; no re-grant to master 0 until its req drops.
REQ-043 Test 5: rst_i asserted during an ownership with flash_csb_o=0 -> next cycle flash_csb_o=1, gnt_o=0; the next tie is won by master 0.
REQ-044 Test 6: owner sends 0xA5 and the flash returns 0x3C on flash_sd_i -> the owner's m_sd_o sees 0x3C in the same cycle; the non-owner's m_sd_o stays 0.
